// File: rtl/accel_layer_sequencer.sv
// Layer sequencer: buffers descriptors and replays each one to the convolution accelerator
// as ten custom-opcode words. The WAIT watchdog is compiled in with ACCEL_SEQ_TIMEOUT_EN.
module accel_layer_sequencer #(
  parameter int DESC_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [112:0]                  desc_data,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic                          run,
  input  logic                          accel_done,
  output logic [31:0]                   accel_instruction,
  output logic                          accel_rst_ext,
  output logic                          busy,
  output logic                          layer_done,
  output logic [15:0]                   layers_completed,
  output logic [$clog2(DESC_DEPTH):0]   desc_count,
  output logic                          timeout_err
);

  localparam int PW = $clog2(DESC_DEPTH);
  localparam int CW = PW + 1;

  if (DESC_DEPTH < 2 || (DESC_DEPTH & (DESC_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 3) begin : g_bad_param
    $error("accel_layer_sequencer: invalid DESC_DEPTH or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [3:0]      idx, idx_nxt;
  logic [1:0]      mask_cnt, mask_cnt_nxt;
  logic            retire_ok;
  logic [112:0]    mem [DESC_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;
  logic [CW-1:0]   count_nxt;
  logic [112:0]    head;

  assign push      = desc_valid & desc_ready;
  assign pop       = (state == S_DONE);
  assign count_nxt = desc_count + CW'(push) - CW'(pop);
  assign head      = mem[rd_ptr];

  function automatic logic [31:0] make_word(input logic [3:0] i, input logic [112:0] d);
    logic [19:0] imm;
    logic [4:0]  rd;
    imm = '0;
    rd  = '0;
    case (i)
      4'd0: begin imm = {12'b0, d[7:0]};   rd = 5'd0; end
      4'd1: begin imm = {11'b0, d[16:8]};  rd = 5'd1; end
      4'd2: begin imm = d[36:17];          rd = 5'd2; end
      4'd3: begin imm = d[56:37];          rd = 5'd3; end
      4'd4: begin imm = d[76:57];          rd = 5'd4; end
      4'd5: begin imm = {18'b0, d[78:77]}; rd = 5'd5; end
      4'd6: begin imm = {17'b0, d[81:79]}; rd = 5'd6; end
      4'd7: begin imm = {7'b0, d[94:82]};  rd = 5'd7; end
      4'd8: begin imm = {2'b0, d[112:95]}; rd = 5'd8; end
      4'd9: begin imm = '0;                rd = 5'd31; end
      default: begin imm = '0; rd = '0; end
    endcase
    return {imm, rd, 7'b0001011};
  endfunction

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;
  logic           timeout_hit;
`endif

  // mask_cnt saturates at 2 so a done left over from the previous layer is ignored.
  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    mask_cnt_nxt = mask_cnt;
    retire_ok    = 1'b0;
`ifdef ACCEL_SEQ_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
    timeout_hit  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (run && desc_count != '0) begin
          state_nxt = S_ISSUE;
          idx_nxt   = 4'd0;
        end
      end
      S_ISSUE: begin
        if (idx == 4'd9) begin
          state_nxt    = S_WAIT;
          mask_cnt_nxt = 2'd0;
`ifdef ACCEL_SEQ_TIMEOUT_EN
          wait_cnt_nxt = '0;
`endif
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      S_WAIT: begin
        if (mask_cnt == 2'd2 && accel_done) begin
          state_nxt = S_DONE;
          retire_ok = 1'b1;
        end else begin
          if (mask_cnt != 2'd2) mask_cnt_nxt = mask_cnt + 2'd1;
`ifdef ACCEL_SEQ_TIMEOUT_EN
          if (wait_cnt == WCW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt   = S_DONE;
            timeout_hit = 1'b1;
          end else begin
            wait_cnt_nxt = wait_cnt + WCW'(1);
          end
`endif
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      idx               <= '0;
      mask_cnt          <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      desc_count        <= '0;
      desc_ready        <= 1'b1;
      accel_instruction <= '0;
      accel_rst_ext     <= 1'b1;
      busy              <= 1'b0;
      layer_done        <= 1'b0;
      layers_completed  <= '0;
    end else begin
      state             <= state_nxt;
      idx               <= idx_nxt;
      mask_cnt          <= mask_cnt_nxt;
      if (push) wr_ptr  <= wr_ptr + PW'(1);
      if (pop)  rd_ptr  <= rd_ptr + PW'(1);
      desc_count        <= count_nxt;
      desc_ready        <= (count_nxt != CW'(DESC_DEPTH));
      accel_instruction <= (state_nxt == S_ISSUE) ? make_word(idx_nxt, head) : 32'h0;
      accel_rst_ext     <= (state_nxt == S_IDLE) || (state_nxt == S_DONE);
      busy              <= (state_nxt != S_IDLE);
      layer_done        <= retire_ok;
      if (retire_ok) layers_completed <= layers_completed + 16'd1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= desc_data;
  end

`ifdef ACCEL_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= timeout_err | timeout_hit;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_accel_layer_sequencer.sv
// Bench for accel_layer_sequencer: directed scenarios plus random traffic, all checked
// every cycle against a queue-based timeline model of the layer sequence.
module tb_accel_layer_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam int LO [9] = '{0, 8, 17, 37, 57, 77, 79, 82, 95};
  localparam int WD [9] = '{8, 9, 20, 20, 20, 2, 3, 13, 18};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [112:0] desc_data = '0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic         run = 1'b0;
  logic         man_done = 1'b0;
  logic         rand_done = 1'b0;
  logic         auto_done = 1'b0;
  logic         accel_done;
  logic [31:0]  accel_instruction;
  logic         accel_rst_ext, busy, layer_done, timeout_err;
  logic [15:0]  layers_completed;
  logic [2:0]   desc_count;

  int checks = 0;
  int errors = 0;

  assign accel_done = auto_done ? rand_done : man_done;

  always #5 clk = ~clk;

  accel_layer_sequencer #(.DESC_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .desc_data(desc_data), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .run(run), .accel_done(accel_done),
    .accel_instruction(accel_instruction), .accel_rst_ext(accel_rst_ext),
    .busy(busy), .layer_done(layer_done), .layers_completed(layers_completed),
    .desc_count(desc_count), .timeout_err(timeout_err)
  );

  // Model: lt is the cycle offset inside a layer (0..9 words, 10.. WAIT), -1 when not running.
  logic [112:0] mq [$];
  int lt = -1;
  bit in_done = 0, done_ok = 0, tmo_err = 0;
  int completed = 0;

  function automatic logic [31:0] exp_word(input logic [112:0] d, input int i);
    logic [112:0] s;
    logic [19:0]  m, imm;
    if (i == 9) return {20'h0, 5'd31, 7'h0B};
    s   = d >> LO[i];
    m   = (20'd1 << WD[i]) - 20'd1;
    imm = s[19:0] & m;
    return {imm, 5'(i), 7'h0B};
  endfunction

  function automatic logic [112:0] pack_desc(input int dim, input int dep, input int ioff,
      input int foff, input int ooff, input int hs, input int st, input int len, input int bias);
    return {18'(bias), 13'(len), 3'(st), 2'(hs), 20'(ooff), 20'(foff), 20'(ioff), 9'(dep), 8'(dim)};
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit push_now;
    int w;
    if (rst) begin
      mq.delete(); lt = -1; in_done = 0; done_ok = 0; completed = 0; tmo_err = 0;
    end else begin
      push_now = desc_valid && (mq.size() != DEPTH);
      if (in_done) begin
        void'(mq.pop_front());
        in_done = 0; done_ok = 0;
      end else if (lt < 0) begin
        if (run && mq.size() != 0) lt = 0;
      end else if (lt < 10) begin
        lt++;
      end else begin
        w = lt - 9;
        if (w >= 3 && accel_done) begin
          in_done = 1; done_ok = 1; completed = (completed + 1) % 65536; lt = -1;
        end
`ifdef ACCEL_SEQ_TIMEOUT_EN
        else if (w >= TMO) begin
          in_done = 1; done_ok = 0; tmo_err = 1; lt = -1;
        end
`endif
        else lt++;
      end
      if (push_now) mq.push_back(desc_data);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("instruction", accel_instruction,
                  (lt >= 0 && lt < 10) ? exp_word(mq[0], lt) : 32'h0);
      checkOutput("accel_rst_ext", 32'(accel_rst_ext), 32'(lt < 0));
      checkOutput("busy", 32'(busy), 32'(lt >= 0 || in_done));
      checkOutput("layer_done", 32'(layer_done), 32'(in_done && done_ok));
      checkOutput("layers_completed", 32'(layers_completed), 32'(completed));
      checkOutput("desc_count", 32'(desc_count), 32'(mq.size()));
      checkOutput("desc_ready", 32'(desc_ready), 32'(mq.size() != DEPTH));
      checkOutput("timeout_err", 32'(timeout_err), 32'(tmo_err));
    end
  end

  always @(posedge clk) begin
    #2 rand_done = ($urandom_range(0, 1) == 0);
  end

  task automatic reset_dut();
    rst = 1'b1; run = 1'b0; desc_valid = 1'b0; man_done = 1'b0; auto_done = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Offers one descriptor and returns 2 time units after the edge that accepted it.
  task automatic applyStimulus(input logic [112:0] d);
    int n = 0;
    desc_valid = 1'b1;
    desc_data  = d;
    while (mq.size() == DEPTH && n < 400) begin
      @(posedge clk); #2; n++;
    end
    checkOutput("push accepted in bound", 32'(n < 400), 32'd1);
    @(posedge clk); #2;
    desc_valid = 1'b0;
  endtask

  task automatic wait_lt(input int min_lt, input string name);
    int n = 0;
    while (lt < min_lt && n < 200) begin
      @(posedge clk); #2; n++;
    end
    checkOutput(name, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_completed(input int target, input string name);
    int n = 0;
    while (completed != target && n < 2000) begin
      @(posedge clk); #2; n++;
    end
    checkOutput(name, 32'(layers_completed), 32'(target));
  endtask

  logic [31:0] lit_words [10] = '{32'h0001C00B, 32'h0000308B, 32'h0010010B, 32'h2000018B,
                                  32'h3000020B, 32'h0000128B, 32'h0000130B, 32'h0001B38B,
                                  32'h0000540B, 32'h00000F8B};

  initial begin
    logic [112:0] d1;
    logic [127:0] r;
    #1000000;
    $display("[TB] FAIL global time limit: got expired, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [112:0] d1;
    logic [127:0] r;
    d1 = pack_desc(28, 3, 'h00100, 'h20000, 'h30000, 1, 1, 27, 5);

    // Reset values
    reset_dut();
    checkOutput("reset instr", accel_instruction, 32'h0);
    checkOutput("reset rst_ext", 32'(accel_rst_ext), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset ready", 32'(desc_ready), 32'd1);
    checkOutput("reset count", 32'(desc_count), 32'd0);

    // Single layer with literal word sequence
    $display("[TB] single layer");
    run = 1'b1;
    applyStimulus(d1);
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("literal word %0d", i), accel_instruction, lit_words[i]);
    end
    repeat (20) @(posedge clk);
    #2 man_done = 1'b1;
    @(posedge clk); #2 man_done = 1'b0;
    checkOutput("single layer_done", 32'(layer_done), 32'd1);
    checkOutput("single completed", 32'(layers_completed), 32'd1);
    @(posedge clk); #2;
    checkOutput("single pulse width", 32'(layer_done), 32'd0);
    checkOutput("single rst_ext idle", 32'(accel_rst_ext), 32'd1);

    // Stale done held high: retires in WAIT cycle 3
    $display("[TB] stale done");
    reset_dut();
    run = 1'b1; man_done = 1'b1;
    applyStimulus(d1);
    repeat (13) begin @(posedge clk); #2; end
    checkOutput("stale wait3 layer_done", 32'(layer_done), 32'd0);
    checkOutput("stale wait3 rst_ext", 32'(accel_rst_ext), 32'd0);
    @(posedge clk); #2;
    checkOutput("stale done layer_done", 32'(layer_done), 32'd1);
    checkOutput("stale done rst_ext", 32'(accel_rst_ext), 32'd1);
    @(posedge clk); #2;
    checkOutput("stale idle rst_ext", 32'(accel_rst_ext), 32'd1);
    checkOutput("stale idle count", 32'(desc_count), 32'd0);
    man_done = 1'b0;

    // FIFO full with run low, then drain in order
    $display("[TB] fifo full");
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(r[112:0]);
    end
    checkOutput("full ready", 32'(desc_ready), 32'd0);
    checkOutput("full count", 32'(desc_count), 32'd4);
    auto_done = 1'b1; run = 1'b1;
    r = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(r[112:0]);
    wait_completed(5, "fifo layers_completed");
    auto_done = 1'b0;

    // Reset at word index 4
    $display("[TB] reset mid-issue");
    reset_dut();
    run = 1'b1;
    applyStimulus(d1);
    repeat (5) begin @(posedge clk); #2; end
    checkOutput("index4 word", accel_instruction, lit_words[4]);
    #1 rst = 1'b1;
    #1;
    checkOutput("async rst_ext", 32'(accel_rst_ext), 32'd1);
    checkOutput("async instr", accel_instruction, 32'h0);
    checkOutput("async busy", 32'(busy), 32'd0);
    checkOutput("async count", 32'(desc_count), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (15) begin
      @(posedge clk); #2;
      checkOutput("post reset no words", accel_instruction, 32'h0);
    end

    // Run gating during WAIT
    $display("[TB] run gating");
    reset_dut();
    run = 1'b1;
    applyStimulus(d1);
    applyStimulus(pack_desc(7, 1, 1, 2, 3, 0, 2, 9, 1));
    wait_lt(10, "gating reach WAIT");
    run = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    man_done = 1'b1;
    @(posedge clk); #2 man_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
      checkOutput("gated busy", 32'(busy), 32'd0);
      checkOutput("gated count", 32'(desc_count), 32'd1);
    end
    run = 1'b1;
    wait_lt(12, "gating second WAIT");
    man_done = 1'b1;
    @(posedge clk); #2 man_done = 1'b0;
    wait_completed(2, "gating completed");

    // Random traffic
    $display("[TB] random traffic");
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      desc_data  = r[112:0];
      desc_valid = ($urandom_range(0, 2) == 0);
      run        = ($urandom_range(0, 7) != 0);
      man_done   = ($urandom_range(0, 2) == 0);
      @(posedge clk); #2;
    end
    desc_valid = 1'b0; man_done = 1'b0;

`ifdef ACCEL_SEQ_TIMEOUT_EN
    $display("[TB] watchdog");
    reset_dut();
    run = 1'b1;
    applyStimulus(d1);
    applyStimulus(pack_desc('h55, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (25) begin @(posedge clk); #2; end
    checkOutput("tmo last wait err", 32'(timeout_err), 32'd0);
    checkOutput("tmo last wait busy", 32'(busy), 32'd1);
    @(posedge clk); #2;
    checkOutput("tmo err set", 32'(timeout_err), 32'd1);
    checkOutput("tmo no layer_done", 32'(layer_done), 32'd0);
    checkOutput("tmo completed", 32'(layers_completed), 32'd0);
    @(posedge clk); #2;
    checkOutput("tmo popped", 32'(desc_count), 32'd1);
    @(posedge clk); #2;
    checkOutput("tmo next layer word", accel_instruction, 32'h0005500B);
    repeat (5) begin @(posedge clk); #2; end
    checkOutput("tmo sticky", 32'(timeout_err), 32'd1);
`else
    $display("[TB] wait persists");
    reset_dut();
    run = 1'b1;
    applyStimulus(d1);
    repeat (60) begin @(posedge clk); #2; end
    checkOutput("persist busy", 32'(busy), 32'd1);
    checkOutput("persist timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("persist count", 32'(desc_count), 32'd1);
`endif

    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
